// File: rtl/exe_muldiv_if.sv
// Issue/result bundle between the execute stage and the multi-cycle multiply/divide unit.
interface exe_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, src1, src2, flush,
    input  busy, stall_req, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src1, src2, flush,
    output busy, stall_req, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/exe_muldiv.sv
// Multi-cycle radix-2 multiply (shift-add) / restoring divide producing HI/LO.
// Operands are iterated as magnitudes; signs are applied in a single FIX cycle.
module exe_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic       clk,
  input logic       rst,
  exe_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 is_div_q, sign1_q, sign2_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     dvs_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 dbz_q;

  logic                 accept, zero_div;
  logic                 s1, s2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign accept   = bus.start & ~bus.flush;
  assign zero_div = bus.op[1] & (bus.src2 == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = zero_div ? DONE : RUN;
      RUN:  if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.stall_req = ((state_q == IDLE) & accept) | (state_q == RUN) | (state_q == FIX);
  end

  always_comb begin
    s1   = ~bus.op[0] & bus.src1[WIDTH-1];
    s2   = ~bus.op[0] & bus.src2[WIDTH-1];
    mag1 = s1 ? '0 - bus.src1 : bus.src1;
    mag2 = s2 ? '0 - bus.src2 : bus.src2;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix = (sign1_q ^ sign2_q) ? '0 - acc_q : acc_q;
    quo_fix  = (sign1_q ^ sign2_q) ? '0 - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign1_q ? '0 - acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      acc_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          cnt_q    <= '0;
          is_div_q <= bus.op[1];
          sign1_q  <= s1;
          sign2_q  <= s2;
          acc_q    <= {{WIDTH{1'b0}}, mag1};
          dvs_q    <= mag2;
          if (zero_div) begin
            hi_q  <= bus.src1;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: if (!bus.flush) begin
          hi_q  <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_q  <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          dbz_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: a 32-bit instance for the main sequence, an 8-bit one for width scaling.
module tb_exe_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_muldiv_if #(.WIDTH(32)) b32 ();
  exe_muldiv_if #(.WIDTH(8))  b8 ();

  exe_muldiv #(.WIDTH(32)) dut   (.clk(clk), .rst(rst), .bus(b32));
  exe_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned e0;
    int unsigned edges;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned stall_cnt = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model; edges counts clock edges after the one that samples start.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
    exp_t        e;
    logic [63:0] p, q, r;
    longint      sa, sbv;
    e.name = name; e.dbz = 1'b0; e.edges = 33; e.e0 = 0;
    p = '0; q = '0; r = '0;
    case (op)
      MULT:  begin sa = longint'($signed(a)); sbv = longint'($signed(b)); p = sa * sbv; end
      MULTU: p = {32'b0, a} * {32'b0, b};
      DIV: if (b != 0) begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        q = sa / sbv; r = sa % sbv;
      end
      default: if (b != 0) begin
        q = {32'b0, a} / {32'b0, b}; r = {32'b0, a} % {32'b0, b};
      end
    endcase
    if (op[1]) begin
      if (b == 0) begin
        e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.edges = 0;
      end else begin
        e.hi = r[31:0]; e.lo = q[31:0];
      end
    end else begin
      e.hi = p[63:32]; e.lo = p[31:0];
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (b32.stall_req === 1'b1) stall_cnt <= stall_cnt + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b32.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, b32.hi, e.hi);
        check({e.name, "_lo"}, b32.lo, e.lo);
        check({e.name, "_dbz"}, b32.div_by_zero, e.dbz);
        check({e.name, "_latency"}, cyc - e.e0, e.edges);
        check({e.name, "_stall_in_done"}, b32.stall_req, 0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name, input bit push);
    exp_t e;
    @(posedge clk); #1;
    b32.start = 1'b1; b32.op = op; b32.src1 = a; b32.src2 = b;
    @(posedge clk); #1;
    b32.start = 1'b0;
    if (push) begin
      e = model(op, a, b, name);
      e.e0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (b32.busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] save_hi, save_lo;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          n;

    b32.start = 1'b0; b32.op = '0; b32.src1 = '0; b32.src2 = '0; b32.flush = 1'b0;
    b8.start  = 1'b0; b8.op  = '0; b8.src1  = '0; b8.src2  = '0; b8.flush  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", b32.busy, 0);
    check("rst_done", b32.done, 0);
    check("rst_stall", b32.stall_req, 0);
    check("rst_hi", b32.hi, 0);
    check("rst_lo", b32.lo, 0);
    check("rst_dbz", b32.div_by_zero, 0);
    rst = 1'b0;

    stall_cnt = 0;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1);
    wait_idle("multu_max");
    check("multu_max_stall_cycles", stall_cnt, 34);

    issue(MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5", 1);            wait_idle("t");
    issue(MULT, 32'h8000_0000, 32'h8000_0000, "mult_minxmin", 1);   wait_idle("t");
    issue(DIV,  32'hFFFF_FFF9, 32'd2, "div_m7d2", 1);               wait_idle("t");
    issue(DIVU, 32'd7, 32'd2, "divu_7d2", 1);                        wait_idle("t");
    issue(DIV,  32'd7, 32'hFFFF_FFFE, "div_7dm2", 1);               wait_idle("t");
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1);        wait_idle("t");
    issue(DIVU, 32'h0000_1234, 32'd0, "divu_by0", 1);               wait_idle("t");

    // Flush mid-RUN: results must keep the divide-by-zero values.
    save_hi = b32.hi; save_lo = b32.lo;
    issue(MULTU, 32'hDEAD_BEEF, 32'h1234_5678, "flushed", 0);
    repeat (9) @(posedge clk);
    #1 b32.flush = 1'b1;
    @(posedge clk); #1 b32.flush = 1'b0;
    check("flush_busy", b32.busy, 0);
    check("flush_hi_hold", b32.hi, save_hi);
    check("flush_lo_hold", b32.lo, save_lo);
    check("flush_dbz_hold", b32.div_by_zero, 1);
    repeat (40) @(posedge clk);
    issue(MULTU, 32'd2, 32'd3, "multu_2x3", 1);                     wait_idle("t");

    // start pulsed during RUN must not restart or queue.
    issue(DIVU, 32'd100, 32'd7, "divu_100d7", 1);
    repeat (5) @(posedge clk);
    #1 b32.start = 1'b1; b32.op = MULTU; b32.src1 = 32'd3; b32.src2 = 32'd3;
    @(posedge clk); #1 b32.start = 1'b0;
    wait_idle("start_in_run");
    repeat (3) @(posedge clk);
    #1 check("start_in_run_idle", b32.busy, 0);

    @(posedge clk); #1;
    b32.start = 1'b1; b32.flush = 1'b1; b32.op = MULTU; b32.src1 = 32'd9; b32.src2 = 32'd9;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.flush = 1'b0;
    check("flush_start_busy", b32.busy, 0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 0) rb = 32'd1;
      issue(rop, ra, rb, $sformatf("rand%0d", i), 1);
      wait_idle("rand");
    end

    issue(MULT, 32'h0000_7777, 32'hFFFF_0001, "rst_victim", 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", b32.busy, 0);
    check("midrst_done", b32.done, 0);
    check("midrst_stall", b32.stall_req, 0);
    check("midrst_hi", b32.hi, 0);
    check("midrst_lo", b32.lo, 0);
    check("midrst_dbz", b32.div_by_zero, 0);
    rst = 1'b0;

    @(posedge clk); #1;
    b8.start = 1'b1; b8.op = MULTU; b8.src1 = 8'hFF; b8.src2 = 8'hFF;
    @(posedge clk); #1;
    b8.start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (b8.done !== 1'b1 && n < 40);
    check("w8_latency", n, 9);
    check("w8_hi", b8.hi, 8'hFE);
    check("w8_lo", b8.lo, 8'h01);

    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
